// File: rtl/averaging_accumulator.sv
// Averaging accumulator: sums sample_count samples between clear and show,
// then publishes the truncated mean and holds it until the next publish.
module averaging_accumulator #(
    parameter int unsigned sample_width = 12,
    parameter int unsigned sample_count = 16
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [sample_width-1:0]         sample,
    input  logic                            clear,
    input  logic                            add,
    input  logic                            show,
    output logic [sample_width-1:0]         average,
    output logic                            average_valid,
    output logic [$clog2(sample_count):0]   sample_counter,
    output logic                            overrun,
    output logic                            incomplete
);

    localparam int unsigned LOG2 = $clog2(sample_count);
    localparam int unsigned CW   = LOG2 + 1;
    localparam int unsigned SUMW = sample_width + LOG2;

    localparam logic [CW-1:0] FULL = CW'(sample_count);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACC  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    if (sample_count < 2 || (sample_count & (sample_count - 1)) != 0) begin : g_bad_count
        $error("averaging_accumulator: sample_count must be a power of two >= 2");
    end

    logic [1:0]              state_q, state_d;
    logic [SUMW-1:0]         sum_q, sum_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [sample_width-1:0] avg_q, avg_d;
    logic                    valid_q, valid_d;
    logic                    ovr_q, ovr_d;
    logic                    inc_q, inc_d;
    logic                    add_prev_q, show_prev_q;
    logic                    add_rise, show_rise;

    assign add_rise  = add & ~add_prev_q;
    assign show_rise = show & ~show_prev_q;

    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        avg_d   = avg_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        inc_d   = inc_q;
        // clear wins over show and add; a coincident add sample is dropped
        if (clear) begin
            state_d = ST_ACC;
            sum_d   = '0;
            cnt_d   = '0;
            ovr_d   = 1'b0;
        end else begin
            case (state_q)
                ST_ACC: begin
                    if (show_rise) begin
                        state_d = ST_DONE;
                        avg_d   = sum_q[SUMW-1:LOG2];
                        valid_d = 1'b1;
                        inc_d   = (cnt_q != FULL);
                    end else if (add_rise) begin
                        if (cnt_q < FULL) begin
                            sum_d = sum_q + SUMW'(sample);
                            cnt_d = cnt_q + 1'b1;
                        end else begin
                            ovr_d = 1'b1;
                        end
                    end
                end
                ST_IDLE, ST_DONE: ;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            sum_q       <= '0;
            cnt_q       <= '0;
            avg_q       <= '0;
            valid_q     <= 1'b0;
            ovr_q       <= 1'b0;
            inc_q       <= 1'b0;
            add_prev_q  <= 1'b0;
            show_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sum_q       <= sum_d;
            cnt_q       <= cnt_d;
            avg_q       <= avg_d;
            valid_q     <= valid_d;
            ovr_q       <= ovr_d;
            inc_q       <= inc_d;
            add_prev_q  <= add;
            show_prev_q <= show;
        end
    end

    assign average        = avg_q;
    assign average_valid  = valid_q;
    assign sample_counter = cnt_q;
    assign overrun        = ovr_q;
    assign incomplete     = inc_q;

endmodule

// File: tb/tb_averaging_accumulator.sv
// Randomized and directed bench for averaging_accumulator with a queue-based
// scoreboard fed by a sample-list reference model.
module tb_averaging_accumulator;

    localparam int unsigned SW = 12;
    localparam int unsigned N  = 16;

    logic                     clock = 1'b0;
    logic                     reset = 1'b0;
    logic [SW-1:0]            sample = '0;
    logic                     clear = 1'b0;
    logic                     add = 1'b0;
    logic                     show = 1'b0;
    logic [SW-1:0]            average;
    logic                     average_valid;
    logic [$clog2(N):0]       sample_counter;
    logic                     overrun;
    logic                     incomplete;

    averaging_accumulator #(.sample_width(SW), .sample_count(N)) dut (
        .clock(clock), .reset(reset), .sample(sample), .clear(clear),
        .add(add), .show(show), .average(average), .average_valid(average_valid),
        .sample_counter(sample_counter), .overrun(overrun), .incomplete(incomplete)
    );

    always #5 clock = ~clock;

    typedef struct {
        int avg;
        int vld;
        int inc;
        int ovr;
        int cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: list of accepted samples, mean computed by division.
    int   m_samples[$];
    bit   m_open = 0;
    int   m_avg = 0, m_vld = 0, m_inc = 0, m_ovr = 0;
    bit   m_add_prev = 0, m_show_prev = 0;

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_edge(input bit r, input bit c, input bit a, input bit s, input int smp);
        int total;
        if (!r) begin
            m_samples.delete();
            m_open = 0; m_avg = 0; m_vld = 0; m_inc = 0; m_ovr = 0;
            m_add_prev = 0; m_show_prev = 0;
            return;
        end
        if (c) begin
            m_samples.delete();
            m_ovr  = 0;
            m_open = 1;
        end else if (m_open && s && !m_show_prev) begin
            total = 0;
            foreach (m_samples[i]) total += m_samples[i];
            m_avg  = total / N;
            m_vld  = 1;
            m_inc  = (m_samples.size() != N);
            m_open = 0;
        end else if (m_open && a && !m_add_prev) begin
            if (m_samples.size() < N) m_samples.push_back(smp);
            else m_ovr = 1;
        end
        m_add_prev  = a;
        m_show_prev = s;
    endtask

    task automatic step(input bit r, input bit c, input bit a, input bit s, input int smp);
        exp_t e;
        reset = r; clear = c; add = a; show = s; sample = SW'(smp);
        model_edge(r, c, a, s, smp);
        e.avg = m_avg; e.vld = m_vld; e.inc = m_inc; e.ovr = m_ovr; e.cnt = m_samples.size();
        exp_q.push_back(e);
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0);
    endtask

    task automatic pulse_add(input int v);
        step(1, 0, 1, 0, v);
        step(1, 0, 0, 0, v);
    endtask

    task automatic do_clear();
        step(1, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0);
    endtask

    task automatic do_show();
        step(1, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0);
    endtask

    // Monitor: the DUT presents a fresh output set each cycle; compare it on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("average",        int'(average),        e.avg);
                chk("average_valid",  int'(average_valid),  e.vld);
                chk("incomplete",     int'(incomplete),     e.inc);
                chk("overrun",        int'(overrun),        e.ovr);
                chk("sample_counter", int'(sample_counter), e.cnt);
            end
        end
    end

    initial begin
        int r, c, a, s, v;
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("reset_valid", int'(average_valid), 0);
        chk("reset_avg", int'(average), 0);

        // 1: sixteen samples of 100
        do_clear();
        for (int i = 0; i < 16; i++) pulse_add(100);
        do_show();
        chk("t1_avg", int'(average), 100);
        chk("t1_inc", int'(incomplete), 0);
        chk("t1_valid", int'(average_valid), 1);

        // 2: 0..15 truncates to 7; full-scale does not wrap
        do_clear();
        for (int i = 0; i < 16; i++) pulse_add(i);
        step(1, 0, 0, 1, 0);
        chk("t2_latency", int'(average), 7);
        step(1, 0, 0, 0, 0);
        do_clear();
        for (int i = 0; i < 16; i++) pulse_add(4095);
        do_show();
        chk("t2_full", int'(average), 4095);

        // 3: held add counts once; held show publishes once
        do_clear();
        for (int i = 0; i < 5; i++) step(1, 0, 1, 0, 50);
        step(1, 0, 0, 0, 0);
        chk("t3_held_add", int'(sample_counter), 1);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 1, 0);
        pulse_add(3000);
        step(1, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0);
        chk("t3_held_show", int'(average), 3);

        // 4: overrun after 16, then a short acquisition
        do_clear();
        for (int i = 0; i < 17; i++) pulse_add(i == 16 ? 4095 : 32);
        chk("t4_overrun", int'(overrun), 1);
        do_show();
        chk("t4_avg", int'(average), 32);
        do_clear();
        for (int i = 0; i < 8; i++) pulse_add(200);
        do_show();
        chk("t4_half", int'(average), 100);
        chk("t4_inc", int'(incomplete), 1);

        // 5: clear with add discards the sample; old result held during new acquisition
        step(1, 1, 1, 0, 999);
        step(1, 0, 0, 0, 0);
        chk("t5_cnt", int'(sample_counter), 0);
        do_show();
        chk("t5_zero", int'(average), 0);
        pulse_add(10);
        do_show();
        do_clear();
        pulse_add(4000);
        chk("t5_hold", int'(average), 0);
        // show coincident with add publishes the prior sum
        step(1, 0, 1, 1, 4000);
        step(1, 0, 0, 0, 0);
        chk("t5_show_add", int'(average), 250);

        // 6: mid-acquisition reset, then show without clear
        do_clear();
        for (int i = 0; i < 5; i++) pulse_add(77);
        step(0, 0, 0, 0, 0);
        chk("t6_valid", int'(average_valid), 0);
        chk("t6_cnt", int'(sample_counter), 0);
        idle(1);
        do_show();
        chk("t6_no_clear", int'(average_valid), 0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 299) != 0);
            c = ($urandom_range(0, 24) == 0);
            a = $urandom_range(0, 1);
            s = ($urandom_range(0, 14) == 0);
            case ($urandom_range(0, 3))
                0: v = 0;
                1: v = 4095;
                default: v = $urandom_range(0, 4095);
            endcase
            step(r, c, a, s, v);
        end
        idle(2);
        @(negedge clock);
        #1;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
